// File: rtl/sample_clock_gen.sv
// rtl/sample_clock_gen.sv - sample clock divider with ADC/DAC gating and wrapping sample address
module sample_clock_gen #(
    parameter int HALF_DIV = 3125,
    parameter int CNT_W    = 12,
    parameter int FF_SHIFT = 1,
    parameter int ADDR_W   = 16,
    parameter int ADDR_MAX = 65535
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [2:0]        State,
    input  logic              AddrClr,
    output logic              Clk1,
    output logic              ClkAD,
    output logic              ClkDA,
    output logic              SampleStb,
    output logic [ADDR_W-1:0] Addr,
    output logic              AddrWrap,
    output logic              Busy
);

    localparam logic [2:0] MODE_IDLE = 3'b000;
    localparam logic [2:0] MODE_REC  = 3'b001;
    localparam logic [2:0] MODE_PLAY = 3'b100;
    localparam logic [2:0] MODE_FF   = 3'b110;
    localparam logic [2:0] MODE_REW  = 3'b111;

    localparam logic [CNT_W-1:0]  LAST_NORM = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0]  LAST_FAST = CNT_W'((HALF_DIV >> FF_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

    logic [2:0]        r_mode;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_clk1;
    logic              r_clk_ad;
    logic              r_clk_da;
    logic              r_stb;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wrap;
    logic              r_busy;

    logic [2:0]        w_state_dec;
    logic              w_active;
    logic [2:0]        w_eff_mode;
    logic [CNT_W-1:0]  w_last_cnt;
    logic              w_terminal;
    logic [2:0]        w_mode_nxt;
    logic              w_clk1_nxt;
    logic              w_ad_nxt;
    logic              w_da_nxt;
    logic              w_stb_nxt;

    always_comb begin
        w_state_dec = MODE_IDLE;
        case (State)
            MODE_REC, MODE_PLAY, MODE_FF, MODE_REW: w_state_dec = State;
            default:                                w_state_dec = MODE_IDLE;
        endcase
    end

    // Divisor follows the latched mode; from idle the incoming mode sets it straight away
    always_comb begin
        w_active   = (w_state_dec != MODE_IDLE);
        w_eff_mode = (r_mode == MODE_IDLE) ? w_state_dec : r_mode;
        w_last_cnt = (w_eff_mode == MODE_FF || w_eff_mode == MODE_REW) ? LAST_FAST : LAST_NORM;
        w_terminal = w_active && (r_cnt >= w_last_cnt);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_mode <= MODE_IDLE;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (!w_active) begin
            w_mode_nxt = MODE_IDLE;
        end else if (r_mode == MODE_IDLE || w_terminal) begin
            w_mode_nxt = w_state_dec;
        end
    end

    always_comb begin
        w_clk1_nxt = w_terminal ? ~r_clk1 : r_clk1;
        w_ad_nxt   = (w_mode_nxt == MODE_REC) && w_clk1_nxt;
        w_da_nxt   = (w_mode_nxt == MODE_PLAY || w_mode_nxt == MODE_FF ||
                      w_mode_nxt == MODE_REW) && w_clk1_nxt;
        w_stb_nxt  = w_terminal && !r_clk1;
    end

    // Idle freezes the count and Clk1 so a resume continues the same half period
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt    <= '0;
            r_clk1   <= 1'b0;
            r_clk_ad <= 1'b0;
            r_clk_da <= 1'b0;
            r_stb    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_active) begin
                r_cnt <= w_terminal ? '0 : r_cnt + CNT_W'(1);
            end
            r_clk1   <= w_clk1_nxt;
            r_clk_ad <= w_ad_nxt;
            r_clk_da <= w_da_nxt;
            r_stb    <= w_stb_nxt;
            r_busy   <= (w_mode_nxt != MODE_IDLE);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_addr <= '0;
            r_wrap <= 1'b0;
        end else if (AddrClr) begin
            r_addr <= '0;
            r_wrap <= 1'b0;
        end else if (r_stb) begin
            if (r_mode == MODE_REW) begin
                r_wrap <= (r_addr == '0);
                r_addr <= (r_addr == '0) ? ADDR_LAST : r_addr - ADDR_W'(1);
            end else begin
                r_wrap <= (r_addr == ADDR_LAST);
                r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + ADDR_W'(1);
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign Clk1      = r_clk1;
    assign ClkAD     = r_clk_ad;
    assign ClkDA     = r_clk_da;
    assign SampleStb = r_stb;
    assign Addr      = r_addr;
    assign AddrWrap  = r_wrap;
    assign Busy      = r_busy;

endmodule
